decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl_pkg.sv | 24 ++
 rtl/decode_ctrl_if.sv | 43 ++++
 rtl/decode_ctrl_bit_aligner.sv | 73 +++++++
 rtl/decode_ctrl.sv | 123 ++++++++++++
 tb/tb_decode_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared types and constants for the bitstream decode controller.
// State encoding, default widths and the bit buffer geometry live here.
package decode_ctrl_pkg;

  localparam int IN_WIDTH_DEF       = 13;
  localparam int NEED_STR_WIDTH_DEF = 4;
  localparam int LEN_WIDTH_DEF      = 16;

  localparam int BUF_W  = 64;
  localparam int WORD_W = 32;
  localparam int CNT_W  = $clog2(BUF_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A whole FIFO word fits only if at most BUF_W-WORD_W bits remain.
  function automatic logic room_for_word(input logic [CNT_W-1:0] cnt);
    return cnt <= CNT_W'(BUF_W - WORD_W);
  endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Job, FIFO, decoder and status signals of the decode controller.
// The controller connects through the slave modport; its environment uses master.
interface decode_ctrl_if #(
  parameter int IN_WIDTH       = decode_ctrl_pkg::IN_WIDTH_DEF,
  parameter int NEED_STR_WIDTH = decode_ctrl_pkg::NEED_STR_WIDTH_DEF,
  parameter int LEN_WIDTH      = decode_ctrl_pkg::LEN_WIDTH_DEF
);

  logic                      job_valid;
  logic [LEN_WIDTH-1:0]      job_len;
  logic                      job_ready;

  logic [31:0]               in_data;
  logic                      in_empty;
  logic                      in_rd;

  logic [IN_WIDTH-1:0]       stream_data;
  logic                      stream_valid;
  logic [NEED_STR_WIDTH-1:0] stream_width;
  logic                      stream_ack;
  logic                      ce_decode;
  logic                      all_end;
  logic                      out_valid;

  logic                      done;
  logic [LEN_WIDTH-1:0]      out_count;
  logic                      err;

  modport master (
    output job_valid, job_len, in_data, in_empty,
    output stream_width, stream_ack, all_end, out_valid,
    input  job_ready, in_rd, stream_data, stream_valid,
    input  ce_decode, done, out_count, err
  );

  modport slave (
    input  job_valid, job_len, in_data, in_empty,
    input  stream_width, stream_ack, all_end, out_valid,
    output job_ready, in_rd, stream_data, stream_valid,
    output ce_decode, done, out_count, err
  );

endinterface

// File: rtl/decode_ctrl_bit_aligner.sv
// MSB-first 64-bit bit buffer: refills whole FIFO words below the valid bits
// and shifts out the decoder's consumed width, presenting an aligned window.
module bit_aligner
  import decode_ctrl_pkg::*;
#(
  parameter int IN_WIDTH       = IN_WIDTH_DEF,
  parameter int NEED_STR_WIDTH = NEED_STR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      run_i,
  input  logic                      refill_en_i,
  input  logic                      words_left_zero_i,
  input  logic [WORD_W-1:0]         in_data_i,
  input  logic                      in_empty_i,
  input  logic [NEED_STR_WIDTH-1:0] stream_width_i,
  input  logic                      stream_ack_i,
  output logic [IN_WIDTH-1:0]       stream_data_o,
  output logic                      stream_valid_o,
  output logic                      in_rd_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      bad_ack_o
);

  logic [BUF_W-1:0] buffer_q, buffer_d, buffer_c;
  logic [CNT_W-1:0] count_q, count_d, count_c;
  logic [CNT_W-1:0] width_ext;
  logic             take;
  logic             shift;

  assign width_ext = CNT_W'(stream_width_i);

  always_comb begin
    stream_valid_o = run_i && ((count_q >= CNT_W'(IN_WIDTH)) ||
                               (words_left_zero_i && (count_q != '0)));
    take      = stream_ack_i && stream_valid_o;
    bad_ack_o = take && ((width_ext == '0) || (width_ext > count_q));
    shift     = take && !bad_ack_o;

    count_c  = shift ? (count_q - width_ext) : count_q;
    buffer_c = shift ? (buffer_q << stream_width_i) : buffer_q;

    // Refill decision uses the post-consumption count so a word can land the same cycle.
    in_rd_o = refill_en_i && !words_left_zero_i && !in_empty_i && room_for_word(count_c);

    buffer_d = buffer_c;
    count_d  = count_c;
    if (in_rd_o) begin
      buffer_d = buffer_c | ({in_data_i, {(BUF_W-WORD_W){1'b0}}} >> count_c);
      count_d  = count_c + CNT_W'(WORD_W);
    end
    if (clear_i) begin
      buffer_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q <= '0;
      count_q  <= '0;
    end else begin
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

  // Bits below count are always zero, so the window zero-fills at end of stream.
  assign stream_data_o = buffer_q[BUF_W-1 -: IN_WIDTH];
  assign count_o       = count_q;

endmodule

// File: rtl/decode_ctrl.sv
// Job-level controller for a variable-length decoder: accepts a job, feeds the
// decoder from a word FIFO through the bit aligner, and reports completion.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int IN_WIDTH       = IN_WIDTH_DEF,
  parameter int NEED_STR_WIDTH = NEED_STR_WIDTH_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  decode_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
  logic [LEN_WIDTH-1:0] out_count_q, out_count_d;
  logic                 err_q, err_d;

  logic                 start;
  logic                 run;
  logic                 refill_en;
  logic                 words_left_zero;
  logic                 pop;
  logic                 bad_ack;
  logic [CNT_W-1:0]     bit_count;

  assign start           = (state_q == ST_IDLE) && bus.job_valid;
  assign run             = (state_q == ST_RUN);
  // Once the end marker is seen, trailing pad words stay in the FIFO.
  assign refill_en       = run && !bus.all_end;
  assign words_left_zero = (words_left_q == '0);

  bit_aligner #(
    .IN_WIDTH       (IN_WIDTH),
    .NEED_STR_WIDTH (NEED_STR_WIDTH)
  ) u_align (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (start),
    .run_i             (run),
    .refill_en_i       (refill_en),
    .words_left_zero_i (words_left_zero),
    .in_data_i         (bus.in_data),
    .in_empty_i        (bus.in_empty),
    .stream_width_i    (bus.stream_width),
    .stream_ack_i      (bus.stream_ack),
    .stream_data_o     (bus.stream_data),
    .stream_valid_o    (bus.stream_valid),
    .in_rd_o           (pop),
    .count_o           (bit_count),
    .bad_ack_o         (bad_ack)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    out_count_d  = out_count_q;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.job_valid) begin
          state_d      = ST_RUN;
          words_left_d = bus.job_len;
          out_count_d  = '0;
          err_d        = 1'b0;
        end
      end
      ST_RUN: begin
        if (pop) begin
          words_left_d = words_left_q - LEN_WIDTH'(1);
        end
        if (bad_ack) begin
          err_d = 1'b1;
        end
        if (bus.all_end) begin
          state_d = ST_DONE;
        end else if (words_left_zero && (bit_count == '0)) begin
          // Stream exhausted without an end marker.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.out_valid && (state_q != ST_IDLE)) begin
      if (out_count_q == '1) begin
        err_d = 1'b1;
      end else begin
        out_count_d = out_count_q + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      out_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      out_count_q  <= out_count_d;
      err_q        <= err_d;
    end
  end

  assign bus.job_ready = (state_q == ST_IDLE);
  assign bus.ce_decode = run;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.in_rd     = pop;
  assign bus.out_count = out_count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: directed jobs push expected windows and
// completion results; a negedge monitor pops and compares them.
module tb_decode_ctrl;
  import decode_ctrl_pkg::*;

  logic clk;
  logic rst;

  decode_ctrl_if #(.IN_WIDTH(13), .NEED_STR_WIDTH(4), .LEN_WIDTH(16)) bus ();

  decode_ctrl #(.IN_WIDTH(13), .NEED_STR_WIDTH(4), .LEN_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        err;
  } done_exp_t;

  logic [12:0] exp_win_q[$];
  done_exp_t   exp_done_q[$];
  logic [31:0] fifo_q[$];
  done_exp_t   e_done;
  logic [12:0] e_win;

  int   total    = 0;
  int   bad      = 0;
  int   rd_count = 0;
  int   max_cnt  = 0;
  int   done_cnt = 0;
  logic rd_neg   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input string act, input string req);
    total++;
    bad++;
    $display("FAIL %s: actual=%s required=%s", name, act, req);
  endtask

  function automatic logic [12:0] win(input logic [127:0] s, input int p);
    logic [127:0] t;
    t = s << p;
    return t[127:115];
  endfunction

  // FIFO model: first-word-fall-through head, popped when in_rd was high at the edge.
  initial begin
    bus.in_data  = '0;
    bus.in_empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rd_neg) begin
        rd_count++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      bus.in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      bus.in_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: compares each accepted window and each done pulse against the queues.
  initial begin
    forever begin
      @(negedge clk);
      rd_neg = bus.in_rd;
      if (!rst) begin
        if (int'(dut.u_align.count_q) > max_cnt) max_cnt = int'(dut.u_align.count_q);
        if (bus.stream_ack && bus.stream_valid) begin
          if (exp_win_q.size() == 0) begin
            flag("unexpected_window", "ack accepted", "no ack");
          end else begin
            e_win = exp_win_q.pop_front();
            check("stream_data", 64'(bus.stream_data), 64'(e_win));
          end
        end
        if (bus.done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) begin
            flag("unexpected_done", "done=1", "done=0");
          end else begin
            e_done = exp_done_q.pop_front();
            check("done_out_count", 64'(bus.out_count), 64'(e_done.cnt));
            check("done_err", 64'(bus.err), 64'(e_done.err));
            check("done_job_ready", 64'(bus.job_ready), 64'd0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic start_job(input logic [15:0] len);
    bus.job_len   = len;
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.stream_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.stream_valid) flag("stream_valid_timeout", "stream_valid=0", "stream_valid=1");
  endtask

  task automatic do_ack(input logic [3:0] w, input logic [12:0] exp);
    wait_valid();
    exp_win_q.push_back(exp);
    bus.stream_width = w;
    bus.stream_ack   = 1'b1;
    tick();
    bus.stream_ack   = 1'b0;
  endtask

  task automatic push_done(input logic [15:0] c, input logic e);
    done_exp_t d;
    d.cnt = c;
    d.err = e;
    exp_done_q.push_back(d);
  endtask

  task automatic wait_idle(input int d0);
    int n = 0;
    while (!bus.job_ready && n < 50) begin
      tick();
      n++;
    end
    check("job_ready_after_done", 64'(bus.job_ready), 64'd1);
    check("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic end_job(input logic [15:0] c, input logic e);
    int d0;
    d0 = done_cnt;
    push_done(c, e);
    bus.all_end = 1'b1;
    tick();
    bus.all_end = 1'b0;
    wait_idle(d0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
    check({tag, "_in_rd"}, 64'(bus.in_rd), 64'd0);
    check({tag, "_ce_decode"}, 64'(bus.ce_decode), 64'd0);
    check({tag, "_stream_valid"}, 64'(bus.stream_valid), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
  endtask

  logic [127:0] s;
  int           r0;
  int           d0;

  initial begin
    rst              = 1'b1;
    bus.job_valid    = 1'b0;
    bus.job_len      = '0;
    bus.stream_width = '0;
    bus.stream_ack   = 1'b0;
    bus.all_end      = 1'b0;
    bus.out_valid    = 1'b0;
    tick();
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single word, acks of 8 then 5.
    load(32'hA500_0000);
    tick();
    tick();
    r0 = rd_count;
    start_job(16'd1);
    do_ack(4'd8, 13'h14A0);
    do_ack(4'd5, 13'h0000);
    check("t1_stream_after_acks", 64'(bus.stream_data), 64'h0);
    check("t1_rd_once", 64'(rd_count - r0), 64'd1);
    end_job(16'd0, 1'b0);

    // Four words, continuous 13-bit acks then the 11-bit tail.
    s = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hF0F0_A55A};
    load(32'hDEAD_BEEF);
    load(32'h0123_4567);
    load(32'h89AB_CDEF);
    load(32'hF0F0_A55A);
    tick();
    tick();
    r0 = rd_count;
    start_job(16'd4);
    wait_valid();
    for (int k = 0; k < 9; k++) begin
      check("t2_no_stall", 64'(bus.stream_valid), 64'd1);
      do_ack(4'd13, win(s, 13 * k));
    end
    check("t2_tail_valid", 64'(bus.stream_valid), 64'd1);
    do_ack(4'd11, win(s, 117));
    end_job(16'd0, 1'b0);
    check("t2_rd_count", 64'(rd_count - r0), 64'd4);

    // Ten output bytes, end marker with a pad word left; job_valid during DONE ignored.
    load(32'h1111_1111);
    load(32'h2222_2222);
    load(32'h3333_3333);
    tick();
    tick();
    r0 = rd_count;
    start_job(16'd3);
    bus.out_valid = 1'b1;
    repeat (10) tick();
    bus.out_valid = 1'b0;
    d0 = done_cnt;
    push_done(16'd10, 1'b0);
    bus.all_end = 1'b1;
    tick();
    bus.all_end = 1'b0;
    check("t3_done_high", 64'(bus.done), 64'd1);
    bus.job_valid = 1'b1;
    bus.job_len   = 16'd5;
    tick();
    bus.job_valid = 1'b0;
    check("t3_ready_after_done", 64'(bus.job_ready), 64'd1);
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);
    tick();
    check("t3_job_in_done_ignored", 64'(bus.ce_decode), 64'd0);
    check("t3_rd_count", 64'(rd_count - r0), 64'd2);
    check("t3_pad_word_left", 64'(fifo_q.size()), 64'd1);
    fifo_q.delete();
    tick();
    tick();

    // Underrun: one word fully consumed without an end marker.
    s = {32'hCAFE_F00D, 96'h0};
    load(32'hCAFE_F00D);
    tick();
    tick();
    start_job(16'd1);
    d0 = done_cnt;
    push_done(16'd0, 1'b1);
    do_ack(4'd13, win(s, 0));
    do_ack(4'd13, win(s, 13));
    do_ack(4'd6, win(s, 26));
    wait_idle(d0);
    check("t4_err_sticky", 64'(bus.err), 64'd1);

    // Over-wide and zero-width acks leave the buffer untouched and flag an error.
    s = {32'h1234_5678, 96'h0};
    load(32'h1234_5678);
    tick();
    tick();
    start_job(16'd1);
    do_ack(4'd13, win(s, 0));
    do_ack(4'd10, win(s, 13));
    check("t5_err_cleared", 64'(bus.err), 64'd0);
    do_ack(4'd15, win(s, 23));
    check("t5_err_set", 64'(bus.err), 64'd1);
    check("t5_data_held", 64'(bus.stream_data), 64'(win(s, 23)));
    do_ack(4'd0, win(s, 23));
    do_ack(4'd9, win(s, 23));
    end_job(16'd0, 1'b1);

    // Reset mid-job with 40 bits buffered.
    s = {32'h0F0F_0F0F, 32'h5A5A_5A5A, 64'h0};
    load(32'h0F0F_0F0F);
    load(32'h5A5A_5A5A);
    tick();
    tick();
    start_job(16'd2);
    do_ack(4'd13, win(s, 0));
    do_ack(4'd11, win(s, 13));
    check("t6_count_40", 64'(dut.u_align.count_q), 64'd40);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_idle", 64'(bus.job_ready), 64'd1);

    check("windows_consumed", 64'(exp_win_q.size()), 64'd0);
    check("dones_consumed", 64'(exp_done_q.size()), 64'd0);
    check("max_count_le_64", 64'(max_cnt <= 64), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
